// File: rtl/cushion_queue_if.sv
// Handshake, head-output and forwarding bundle between the execute stage,
// the cushion queue and the memory-read / register-access stages.
interface cushion_queue_if #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 128
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                 FLUSH;
    logic                 MEM_WAIT;

    logic                 IN_VALID;
    logic                 IN_READY;
    logic [31:0]          IN_PC;
    logic                 IN_REG_W_EN;
    logic [4:0]           IN_REG_W_RD;
    logic [31:0]          IN_REG_W_DATA;
    logic                 IN_MEM_R_EN;
    logic [4:0]           IN_MEM_R_RD;
    logic [PAYLOAD_W-1:0] IN_PAYLOAD;

    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [31:0]          OUT_PC;
    logic                 OUT_REG_W_EN;
    logic [4:0]           OUT_REG_W_RD;
    logic [31:0]          OUT_REG_W_DATA;
    logic                 OUT_MEM_R_EN;
    logic [4:0]           OUT_MEM_R_RD;
    logic [PAYLOAD_W-1:0] OUT_PAYLOAD;

    logic                 FULL;
    logic [CW-1:0]        COUNT;

    logic [4:0]           FWD_ADDR;
    logic                 FWD_HIT;
    logic [31:0]          FWD_DATA;
    logic                 FWD_PENDING;

    // Pipeline side: produces entries, consumes the head, asks for forwarding.
    modport master (
        output FLUSH, MEM_WAIT,
        output IN_VALID, IN_PC, IN_REG_W_EN, IN_REG_W_RD, IN_REG_W_DATA,
        output IN_MEM_R_EN, IN_MEM_R_RD, IN_PAYLOAD,
        input  IN_READY,
        input  OUT_VALID, OUT_PC, OUT_REG_W_EN, OUT_REG_W_RD, OUT_REG_W_DATA,
        input  OUT_MEM_R_EN, OUT_MEM_R_RD, OUT_PAYLOAD,
        output OUT_READY,
        input  FULL, COUNT,
        output FWD_ADDR,
        input  FWD_HIT, FWD_DATA, FWD_PENDING
    );

    // Queue side.
    modport slave (
        input  FLUSH, MEM_WAIT,
        input  IN_VALID, IN_PC, IN_REG_W_EN, IN_REG_W_RD, IN_REG_W_DATA,
        input  IN_MEM_R_EN, IN_MEM_R_RD, IN_PAYLOAD,
        output IN_READY,
        output OUT_VALID, OUT_PC, OUT_REG_W_EN, OUT_REG_W_RD, OUT_REG_W_DATA,
        output OUT_MEM_R_EN, OUT_MEM_R_RD, OUT_PAYLOAD,
        input  OUT_READY,
        output FULL, COUNT,
        input  FWD_ADDR,
        output FWD_HIT, FWD_DATA, FWD_PENDING
    );
endinterface

// File: rtl/cushion_queue.sv
// In-order DEPTH-entry buffer between execute and memory-read with
// first-word fall-through head, count-based full/empty and a youngest-first
// associative forwarding search over all pending entries.
module cushion_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 128
) (
    input logic            CLK,
    input logic            RST,
    cushion_queue_if.slave q
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic                 reg_w_en;
        logic [4:0]           reg_w_rd;
        logic [31:0]          reg_w_data;
        logic                 mem_r_en;
        logic [4:0]           mem_r_rd;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             count_q, count_d;

    logic   in_ready, out_valid, push, pop;
    entry_t in_entry, head;
    logic   fwd_hit, fwd_pending;
    logic [31:0] fwd_data;

    assign in_ready  = (count_q != cnt_t'(DEPTH));
    assign out_valid = (count_q != '0) && !q.FLUSH;
    assign push      = q.IN_VALID && in_ready && !q.FLUSH;
    assign pop       = out_valid && q.OUT_READY && !q.MEM_WAIT;

    assign in_entry = '{
        pc:         q.IN_PC,
        reg_w_en:   q.IN_REG_W_EN,
        reg_w_rd:   q.IN_REG_W_RD,
        reg_w_data: q.IN_REG_W_DATA,
        mem_r_en:   q.IN_MEM_R_EN,
        mem_r_rd:   q.IN_MEM_R_RD,
        payload:    q.IN_PAYLOAD
    };

    // Next pointers, count and valid bits; flush discards everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (q.FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = '0;
        end else begin
            if (push) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; contents are qualified by valid_q so need no reset.
    always_ff @(posedge CLK) begin
        if (RST && push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign q.IN_READY       = in_ready;
    assign q.FULL           = !in_ready;
    assign q.COUNT          = count_q;
    assign q.OUT_VALID      = out_valid;
    assign q.OUT_PC         = out_valid ? head.pc         : '0;
    assign q.OUT_REG_W_EN   = out_valid ? head.reg_w_en   : '0;
    assign q.OUT_REG_W_RD   = out_valid ? head.reg_w_rd   : '0;
    assign q.OUT_REG_W_DATA = out_valid ? head.reg_w_data : '0;
    assign q.OUT_MEM_R_EN   = out_valid ? head.mem_r_en   : '0;
    assign q.OUT_MEM_R_RD   = out_valid ? head.mem_r_rd   : '0;
    assign q.OUT_PAYLOAD    = out_valid ? head.payload    : '0;

    // Forwarding search: walk oldest to youngest so the youngest match wins.
    always_comb begin
        ptr_t idx;
        idx         = '0;
        fwd_hit     = 1'b0;
        fwd_pending = 1'b0;
        fwd_data    = '0;
        if (!q.FLUSH && (q.FWD_ADDR != '0)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + ptr_t'(i);
                if (valid_q[idx]) begin
                    // A load that also claims a register write is still
                    // unresolved, so the load match takes precedence.
                    if (mem_q[idx].mem_r_en && (mem_q[idx].mem_r_rd == q.FWD_ADDR)) begin
                        fwd_hit     = 1'b0;
                        fwd_pending = 1'b1;
                        fwd_data    = '0;
                    end else if (mem_q[idx].reg_w_en && (mem_q[idx].reg_w_rd == q.FWD_ADDR)) begin
                        fwd_hit     = 1'b1;
                        fwd_pending = 1'b0;
                        fwd_data    = mem_q[idx].reg_w_data;
                    end
                end
            end
        end
    end

    assign q.FWD_HIT     = fwd_hit;
    assign q.FWD_PENDING = fwd_pending;
    assign q.FWD_DATA    = fwd_data;
endmodule

// File: doc/cushion_queue.md
Name: cushion_queue

Overview:
- Parametrised, multi-entry, in-order buffer between the execute stage and memory-read stage of the core pipeline.
- Generalises the single-entry execute-wait stage to DEPTH entries with a valid/ready handshake, a FULL back-pressure signal, and an associative forwarding search across all pending entries.
- Flush empties the queue. MEM_WAIT freezes the head.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PAYLOAD_W, 128, width of opaque side-band fields carried unmodified (CSR write, mem write, jump, exception fields, packed by the instantiating stage).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-low (state cleared on rising CLK edge while RST=0).
- FLUSH  in  1  discard all entries.
- MEM_WAIT  in  1  memory hazard; blocks pop.
- IN_VALID  in  1  execute result present.
- IN_READY  out  1  queue can accept; equals count<DEPTH.
- IN_PC  in  32  instruction PC.
- IN_REG_W_EN  in  1  entry writes integer register.
- IN_REG_W_RD  in  5  destination register.
- IN_REG_W_DATA  in  32  register write data.
- IN_MEM_R_EN  in  1  entry is a load.
- IN_MEM_R_RD  in  5  load destination register.
- IN_PAYLOAD  in  PAYLOAD_W  opaque fields.
- OUT_VALID  out  1  head entry present.
- OUT_READY  in  1  memory-read stage consumes head.
- OUT_PC, OUT_REG_W_EN, OUT_REG_W_RD, OUT_REG_W_DATA, OUT_MEM_R_EN, OUT_MEM_R_RD, OUT_PAYLOAD  out  as inputs  head entry fields.
- FULL  out  1  count==DEPTH; feeds pipeline stall.
- COUNT  out  $clog2(DEPTH+1)  occupancy.
- FWD_ADDR  in  5  register being read by the register-access stage.
- FWD_HIT  out  1  forwarded value valid.
- FWD_DATA  out  32  forwarded value.
- FWD_PENDING  out  1  youngest match is an unresolved load; requester must stall.

Behaviour:
- Storage: circular array with wr_ptr, rd_ptr of width log2(DEPTH), plus a count register.
  - Pointers wrap modulo DEPTH.
  - Full/empty are decided by count only, never by pointer equality.
- push = IN_VALID && IN_READY && !FLUSH.
- pop = OUT_VALID && OUT_READY && !MEM_WAIT.
- Next count:
  - count+1 on push only.
  - count-1 on pop only.
  - unchanged on both or neither.
- Push at count==DEPTH is impossible because IN_READY=0. A pop in that cycle does not raise IN_READY in the same cycle (no combinational path from OUT_READY to IN_READY).
- Output is first-word fall-through: head fields appear combinationally from the rd_ptr entry.
  - OUT_VALID = (count!=0) && !FLUSH.
  - All OUT_* fields are driven to 0 when OUT_VALID=0.
- MEM_WAIT=1: no pop. Head outputs stay stable. Pushes still accepted while IN_READY=1.
- FLUSH=1:
  - Next cycle count=0 and both pointers are 0.
  - A concurrent IN_VALID is dropped.
  - FLUSH has priority over MEM_WAIT and over push/pop.
- Reset (RST=0 at an edge), including mid-operation:
  - count=0, pointers 0, storage valid bits 0.
  - OUT_VALID=0, IN_READY=1, FULL=0, COUNT=0.
  - FWD_HIT=0, FWD_PENDING=0, FWD_DATA=0.
  - Takes effect the cycle after the edge; RST overrides FLUSH.
- Forwarding (combinational):
  - Search occupied entries from youngest (wr_ptr-1) to oldest (rd_ptr).
  - An entry matches if (REG_W_EN && REG_W_RD==FWD_ADDR) || (MEM_R_EN && MEM_R_RD==FWD_ADDR).
  - The youngest match decides the result:
    - If it is a register write: FWD_HIT=1, FWD_DATA=its REG_W_DATA.
    - If it is a load: FWD_PENDING=1, FWD_HIT=0.
  - FWD_ADDR==0 never matches; all forwarding outputs are 0.
  - When FLUSH=1, all forwarding outputs are 0.
  - The entry being pushed in the current cycle is not searched.
- Latency: a pushed entry is visible at OUT and in the forwarding search on the next cycle.
- Throughput: 1 push and 1 pop per cycle.

Test Plan:
1. Reset, then push PC 0x2000_0000..0x2000_000C with OUT_READY=0 -> COUNT 1..4, FULL=1, IN_READY=0 after the 4th push. Then OUT_READY=1 -> PCs emerge in order, one per cycle.
2. Steady state at COUNT=1 with push and pop each cycle for 10 cycles -> COUNT stays 1, no loss. Pointers wrap past DEPTH-1 with order preserved.
3. Hold MEM_WAIT=1 for 3 cycles with OUT_READY=1 and pushes continuing -> OUT_PC constant, COUNT increments. After MEM_WAIT drops, pops resume.
4. Queue x5 with 0x11, then x5 with 0x22, then load rd=x6; FWD_ADDR=5 -> HIT=1, DATA=0x22. FWD_ADDR=6 -> PENDING=1, HIT=0. FWD_ADDR=0 -> all 0.
5. COUNT=3 plus FLUSH with IN_VALID=1 in the same cycle -> OUT_VALID=0 that cycle; next cycle COUNT=0 and the pushed entry is absent.
6. RST=0 with COUNT=2 and MEM_WAIT=1 -> next cycle all outputs at reset values. After release, first push appears at OUT after 1 cycle.
